// File: rtl/strobe_gen.sv
// Multi-channel programmable strobe generator: each channel counts a loaded
// divide value and emits single-cycle clk-domain enable pulses.
module strobe_gen #(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_oneshot,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [WIDTH-1:0] cnt_q   [NCH];
    logic [WIDTH-1:0] cnt_d   [NCH];
    logic [WIDTH-1:0] div_q   [NCH];
    logic [WIDTH-1:0] div_d   [NCH];
    logic [NCH-1:0]   os_q;
    logic [NCH-1:0]   os_d;
    logic [NCH-1:0]   tick_q;
    logic [NCH-1:0]   tick_d;
    logic [NCH-1:0]   wr_hit;

    // Out-of-range channel indices never match, so such writes are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            os_d[i]    = os_q[i];
            tick_d[i]  = 1'b0;

            if (wr_hit[i]) begin
                div_d[i] = wr_div;
                os_d[i]  = wr_oneshot;
            end

            if (stop[i]) begin
                state_d[i] = IDLE;
            end else if (start[i]) begin
                // A start on the same edge as a write must see the new divide value.
                state_d[i] = RUN;
                cnt_d[i]   = wr_hit[i] ? wr_div : div_q[i];
            end else if (state_q[i] == RUN) begin
                if (cnt_q[i] == '0) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = div_q[i];
                    if (os_q[i]) begin
                        state_d[i] = IDLE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= '0;
            end
            os_q   <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
            end
            os_q   <= os_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == RUN);
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen: an event-scheduling reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_strobe_gen;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic        wr_oneshot;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  tick;
    logic [3:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_gen #(.WIDTH(16), .NCH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .wr_oneshot (wr_oneshot),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each running channel holds the absolute edge number of its next tick.
    int          edge_n;
    int          m_next [4];
    logic [15:0] m_div  [4];
    logic        m_os   [4];
    logic [3:0]  m_run;
    logic [3:0]  m_tick;
    logic        hit;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_n = 0;
            m_run  = '0;
            m_tick = '0;
            for (int i = 0; i < 4; i++) begin
                m_next[i] = 0;
                m_div[i]  = '0;
                m_os[i]   = 1'b0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 4; i++) begin
                hit       = wr_en && (wr_ch == i);
                m_tick[i] = 1'b0;
                if (stop[i]) begin
                    m_run[i] = 1'b0;
                end else if (start[i]) begin
                    m_run[i]  = 1'b1;
                    m_next[i] = edge_n + int'(hit ? wr_div : m_div[i]) + 1;
                end else if (m_run[i] && edge_n == m_next[i]) begin
                    m_tick[i] = 1'b1;
                    m_next[i] = edge_n + int'(m_div[i]) + 1;
                    if (m_os[i]) m_run[i] = 1'b0;
                end
                if (hit) begin
                    m_div[i] = wr_div;
                    m_os[i]  = wr_oneshot;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (tick !== m_tick) begin
            n_fail++;
            $display("[TB] FAIL model_tick t=%0t: got %b want %b", $time, tick, m_tick);
        end
        n_checks++;
        if (busy !== m_run) begin
            n_fail++;
            $display("[TB] FAIL model_busy t=%0t: got %b want %b", $time, busy, m_run);
        end
    end

    task automatic check_output(input string name, input logic [3:0] exp_tick,
                                input logic [3:0] exp_busy);
        n_checks++;
        if (tick !== exp_tick) begin
            n_fail++;
            $display("[TB] FAIL %s tick t=%0t: got %b want %b", name, $time, tick, exp_tick);
        end
        n_checks++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("[TB] FAIL %s busy t=%0t: got %b want %b", name, $time, busy, exp_busy);
        end
    endtask

    // Drives one edge worth of inputs, then returns at the following negedge with inputs cleared.
    task automatic apply_stimulus(input logic we, input logic [1:0] ch, input logic [15:0] d,
                                  input logic os, input logic [3:0] st, input logic [3:0] sp);
        wr_en      = we;
        wr_ch      = ch;
        wr_div     = d;
        wr_oneshot = os;
        start      = st;
        stop       = sp;
        @(negedge clk);
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_oneshot = 1'b0;
        start      = '0;
        stop       = '0;
    endtask

    initial begin
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_oneshot = 1'b0;
        start      = '0;
        stop       = '0;

        $display("[TB] reset with random inputs");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wr_en      = 1'($urandom);
            wr_ch      = 2'($urandom);
            wr_div     = 16'($urandom);
            wr_oneshot = 1'($urandom);
            start      = 4'($urandom);
            stop       = 4'($urandom);
            check_output("reset_hold", 4'b0000, 4'b0000);
        end
        @(negedge clk);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("post_reset_idle", 4'b0000, 4'b0000);
        end

        $display("[TB] periodic ch1 D=3");
        apply_stimulus(1'b1, 2'd1, 16'd3, 1'b0, 4'b0000, 4'b0000);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0000);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_output("periodic", (k % 4 == 0) ? 4'b0010 : 4'b0000, 4'b0010);
        end
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0010);
        check_output("periodic_stop", 4'b0000, 4'b0000);

        $display("[TB] one-shot ch0 D=2");
        apply_stimulus(1'b1, 2'd0, 16'd2, 1'b1, 4'b0000, 4'b0000);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_output("oneshot", (k == 3) ? 4'b0001 : 4'b0000,
                         (k < 3) ? 4'b0001 : 4'b0000);
        end

        $display("[TB] ch2 D=0 continuous");
        apply_stimulus(1'b1, 2'd2, 16'd0, 1'b0, 4'b0000, 4'b0000);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0100, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_output("div_zero", 4'b0100, 4'b0100);
        end
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0100);
        check_output("div_zero_stop", 4'b0000, 4'b0000);

        $display("[TB] live rewrite ch3 D=5 -> D=1");
        apply_stimulus(1'b1, 2'd3, 16'd5, 1'b0, 4'b0000, 4'b0000);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b1000, 4'b0000);
        repeat (2) @(negedge clk);
        apply_stimulus(1'b1, 2'd3, 16'd1, 1'b0, 4'b0000, 4'b0000);
        for (int k = 4; k <= 12; k++) begin
            @(negedge clk);
            check_output("live_rewrite", (k >= 6 && (k - 6) % 2 == 0) ? 4'b1000 : 4'b0000,
                         4'b1000);
        end
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b1000);

        $display("[TB] write and start ch0 on one edge");
        apply_stimulus(1'b1, 2'd0, 16'd4, 1'b0, 4'b0001, 4'b0000);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check_output("write_start", (k == 5 || k == 10) ? 4'b0001 : 4'b0000, 4'b0001);
        end
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0001);

        $display("[TB] start and stop ch0 on one edge");
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0001);
        check_output("start_stop", 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_output("start_stop_idle", 4'b0000, 4'b0000);
        end

        $display("[TB] restart ch1 when count is zero");
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0000);
        repeat (3) @(negedge clk);
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0000);
        check_output("restart_edge", 4'b0000, 4'b0010);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_output("restart", (k == 4 || k == 8) ? 4'b0010 : 4'b0000, 4'b0010);
        end

        $display("[TB] asynchronous reset mid-count");
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0100, 4'b0000);
        repeat (2) @(negedge clk);
        check_output("pre_reset", 4'b0100, 4'b0110);
        #2 reset = 1'b0;
        #1 check_output("reset_async", 4'b0000, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            check_output("reset_mid_hold", 4'b0000, 4'b0000);
        end
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_output("reset_mid_release", 4'b0000, 4'b0000);
        end
        // Config was cleared by reset, so a bare start runs with D=0.
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_output("config_lost", 4'b0010, 4'b0010);
        end
        apply_stimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0010);
        check_output("final_stop", 4'b0000, 4'b0000);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strobe_gen.md
# strobe_gen

Multi-channel programmable strobe (clock-enable) generator driven by the on-chip oscillator clock. Each of NCH independent channels counts a software-loaded divide value and emits single-cycle `tick` pulses, either periodically or as a one-shot. Downstream logic uses these pulses as enables on `clk`-domain registers instead of deriving extra clocks, for example in display scan, audio sample rate and debounce sampling.

## Interface
- `WIDTH`, 16: width of the divide value and of each channel counter.
- `NCH`, 4: number of channels, ≥1.
- `CW`, max(1,$clog2(NCH)): channel-select width (derived, not overridden).

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `wr_en`  in  1  load the config of channel `wr_ch` this cycle.
- `wr_ch`  in  CW  channel index for the write; values ≥NCH are ignored.
- `wr_div`  in  WIDTH  divide value D; tick period is D+1 cycles.
- `wr_oneshot`  in  1  1 = one-shot mode, 0 = periodic.
- `start`  in  NCH  per-channel start/restart request.
- `stop`  in  NCH  per-channel stop request.
- `tick`  out  NCH  registered single-cycle strobe per channel.
- `busy`  out  NCH  channel running.

## Operation
- Per-channel state: `div[i]` (WIDTH), `oneshot[i]` (1), `cnt[i]` (WIDTH), `busy[i]`, `tick[i]`.
- Reset (`reset`=0, async): all `div`, `cnt`, `oneshot`, `busy` and `tick` are 0.
- Config write: on an edge with `wr_en`=1 and `wr_ch`<NCH, `div[wr_ch]`<=`wr_div` and `oneshot[wr_ch]`<=`wr_oneshot`. A running channel's `cnt` is not disturbed, so the new D applies from the next reload.
- Each channel has two states, IDLE (`busy`=0) and RUN (`busy`=1). Priority per channel per edge, highest first:
  1. `stop[i]`: `busy`<=0, `tick`<=0, `cnt` unchanged.
  2. `start[i]`: `busy`<=1, `cnt`<=effective D, `tick`<=0. This restarts a channel that is already running, including one whose `cnt` is 0.
  3. RUN with `cnt`=0: `tick`<=1 and `cnt`<=`div[i]`. In one-shot mode `busy` is also cleared.
  4. RUN with `cnt`≠0: `cnt`<=`cnt`−1, `tick`<=0.
  5. IDLE: `tick`<=0.
- Effective D on start: if the same edge writes this channel, the start uses `wr_div` and `wr_oneshot`. Otherwise it uses the stored values.
- Arithmetic: unsigned. The decrement never underflows because reload happens at 0. D=2^WIDTH−1 is legal and gives period 2^WIDTH.
- Channels are fully independent. A `start` vector with several bits set gives phase-aligned ticks on those channels.

## Timing
- Start sampled at edge E0. `cnt`=D after E0 and `cnt`=D−k after Ek.
- The first tick is high for the cycle following E(D+1), then every D+1 cycles after that.
- D=0: `tick` high on every cycle after E1, i.e. continuously, while running.
- `tick` is never high for more than one cycle unless D=0.
- `busy` rises in the cycle after E0.
- One-shot: `busy` falls on the same edge that raises the single `tick`.
- Stop at edge Es: `tick` and `busy` are 0 from Es onward, with no trailing pulse.
- Reset mid-operation: outputs go to 0 immediately, without waiting for `clk`. After release the channel stays idle until a new `start`; the config is lost.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset`=0 with random inputs. Require `tick`=0, `busy`=0. Release with no start and require both to stay 0 for 20 cycles.
- Periodic: write ch1 D=3, periodic, then start ch1 at E0. Require ticks after E4, E8, E12, … (period 4). `busy[1]`=1 throughout and all other channels silent.
- One-shot and D=0:
  - ch0 D=2 one-shot, start at E0. Require exactly one tick after E3, with `busy[0]` falling at E3 and no further ticks.
  - ch2 D=0 periodic. Require `tick[2]` continuously high from the cycle after E1.
- Live rewrite: ch3 running with D=5. Write D=1 two cycles after E0. Require the first tick still after E6, then ticks every 2 cycles.
- Write+start same edge: write ch0 D=4 and start ch0 on one edge. Require the first tick 5 cycles later, not using the old D.
- Simultaneous events:
  - `start[0]` and `stop[0]` on one edge: require ch0 stays idle.
  - Restart ch1 on the edge where `cnt`=0: require no tick, and the next tick D+1 cycles later.
  - Assert `reset` mid-count: require immediate zeros and silence after release.
